instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Upstream neighbour of cpu_rv32: owns the instruction memory and drives cpu_rv32's instr_load from its lc fetch address.
- Before execution it receives a program as a byte stream (valid/ready), packs the bytes little-endian into 32-bit words and writes them into memory.
- After the last word is written it pulses start_flag so the core begins execution.
- It serves instruction fetches combinationally, matching the timing the core expects.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2**ADDR_W words.
- NOP_WORD, 32'h0000_0013, word returned on fetches while not in RUN (addi x0,x0,0).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  program byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready.
- reload  input  1  one-cycle request to abandon RUN/ERR and accept a new program.
- lc  input  16  byte fetch address from the core.
- instr_load  output  32  instruction word for lc.
- start_flag  output  1  one-cycle pulse to the core.
- loading  output  1  high whenever state is not RUN.
- err_len  output  1  sticky: illegal program length seen.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (async, rst_n=0):
  - state=LEN_LO; rx_ready=1; start_flag=0; err_len=0; words_loaded=0; loading=1.
  - Byte-lane index=0; length register=0.
  - Memory contents are not reset.
- Frame format:
  - Length N: 2 bytes, little-endian word count.
  - Then 4*N bytes, little-endian per word (first byte = bits[7:0]).
- States:
  - LEN_LO: on transfer, latch N[7:0] -> LEN_HI.
  - LEN_HI: on transfer, latch N[15:8]; check the complete N:
    - N==0 or N>2**ADDR_W: set err_len -> ERR.
    - Otherwise -> DATA.
  - DATA: on each transfer, place the byte into lane byte_idx of the holding word.
    - When byte_idx==3, write the full word to mem[words_loaded] in that same clock edge, increment words_loaded and clear byte_idx.
    - If this was word N: -> START.
  - START: start_flag=1 for exactly this cycle; rx_ready=0 -> RUN.
  - RUN: rx_ready=0; loading=0; instr_load=mem[lc[ADDR_W+1:2]] (lc[1:0] ignored; upper lc bits truncated, so addresses wrap).
  - ERR: rx_ready=0; loading=1; stays in ERR until reload.
- reload:
  - Sampled in any state. Next state is LEN_LO, with words_loaded=0, byte_idx=0 and err_len cleared.
  - Takes priority over a simultaneous byte transfer; that byte is accepted but discarded.
- rx_ready:
  - 1 in LEN_LO, LEN_HI and DATA; 0 in START, RUN and ERR.
  - Combinational from state only; it never depends on rx_valid.
- instr_load:
  - Purely combinational (zero latency) from lc and memory.
  - Returns NOP_WORD whenever state!=RUN.
- Write/read collision: a write only happens in DATA and a real read only in RUN, so no simultaneous read and write can occur.
- Latency: start_flag asserts the cycle after the edge that accepts the final byte. The first real fetch is available the cycle after that.
- Reset mid-load: partial words are lost. Memory keeps the words already written; the loader restarts in LEN_LO.
- No back-pressure toward the core.

Test Plan:
- Normal load:
  - Stimulus: bytes 02 00, 13 05 10 00, 93 05 20 00.
  - Required: mem[0]=0x00100513 and mem[1]=0x00200593; start_flag high for exactly 1 cycle, 1 cycle after the final byte; then lc=0 gives 0x00100513 and lc=4 gives 0x00200593 with no delay.
- Gapped valid:
  - Stimulus: the same frame with rx_valid low for 0–3 random cycles between bytes.
  - Required: identical memory contents and a single start_flag pulse; words_loaded=2.
- Length errors:
  - Stimulus: N=0 (00 00), and with ADDR_W=10, N=1025 (01 04).
  - Required: err_len=1, state ERR, rx_ready=0, no start_flag; instr_load=0x00000013 for any lc.
- Reload from RUN:
  - Stimulus: after the normal load, pulse reload, then load N=1 with word 0xDEADBEEF.
  - Required: loading=1 and fetches return NOP during the load; then lc=0 gives 0xDEADBEEF and lc=4 still gives 0x00200593.
- Async reset mid-word:
  - Stimulus: drop rst_n after 2 of the 4 bytes of word 1.
  - Required: outputs at reset values immediately (before the next clock edge); mem[0] retained; the next load restarts from LEN_LO.
- Simultaneous reload and byte transfer in DATA:
  - Required: the byte is discarded, words_loaded=0 and the next byte is taken as the low byte of N.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Program loader and instruction memory for cpu_rv32: packs a length-prefixed
// byte stream into 32-bit words, then serves zero-latency fetches.
module instr_mem_loader #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  input  logic [15:0]       lc,
  output logic [31:0]       instr_load,
  output logic              start_flag,
  output logic              loading,
  output logic              err_len,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    START  = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t       state;
  logic [1:0]   byte_idx;
  logic [15:0]  len_q;
  logic [23:0]  hold_q;
  logic [31:0]  mem [DEPTH];

  logic              xfer;
  logic [15:0]       len_full;
  logic              len_bad;
  logic [CNT_W-1:0]  wl_next;
  logic              last_word;
  logic              mem_we;
  logic              unused_lc;

  // Handshake and status decode purely from the state register
  assign rx_ready   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign start_flag = (state == START);
  assign loading    = (state != RUN);
  assign xfer       = rx_valid && rx_ready;

  assign len_full  = {rx_data, len_q[7:0]};
  assign len_bad   = (len_full == 16'd0) || (17'(len_full) > 17'(DEPTH));
  assign wl_next   = words_loaded + CNT_W'(1);
  assign last_word = (16'(wl_next) == len_q);

  // A reload in the same cycle as the fourth byte suppresses the write
  assign mem_we = (state == DATA) && xfer && (byte_idx == 2'd3) && !reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LEN_LO;
      byte_idx     <= 2'd0;
      len_q        <= 16'd0;
      hold_q       <= 24'd0;
      words_loaded <= '0;
      err_len      <= 1'b0;
    end else if (reload) begin
      state        <= LEN_LO;
      byte_idx     <= 2'd0;
      len_q        <= 16'd0;
      words_loaded <= '0;
      err_len      <= 1'b0;
    end else begin
      case (state)
        LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= rx_data;
            state      <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= rx_data;
            if (len_bad) begin
              err_len <= 1'b1;
              state   <= ERR;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            if (byte_idx == 2'd3) begin
              byte_idx     <= 2'd0;
              words_loaded <= wl_next;
              if (last_word) state <= START;
            end else begin
              case (byte_idx)
                2'd0:    hold_q[7:0]   <= rx_data;
                2'd1:    hold_q[15:8]  <= rx_data;
                default: hold_q[23:16] <= rx_data;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        START:   state <= RUN;
        RUN:     state <= RUN;
        ERR:     state <= ERR;
        default: state <= LEN_LO;
      endcase
    end
  end

  // Instruction storage; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[words_loaded[ADDR_W-1:0]] <= {rx_data, hold_q};
  end

  // Byte offset and address bits above the memory are ignored, so fetches wrap
  assign unused_lc  = ^{lc[15:ADDR_W+2], lc[1:0]};
  assign instr_load = (state == RUN) ? mem[lc[ADDR_W+1:2]] : NOP_WORD;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader against a word-array model of the
// program memory built from the frame format.
`timescale 1ns/1ps
module tb_instr_mem_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              reload;
  logic [15:0]       lc;
  logic [31:0]       instr_load;
  logic              start_flag;
  logic              loading;
  logic              err_len;
  logic [ADDR_W:0]   words_loaded;

  instr_mem_loader #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .lc(lc), .instr_load(instr_load),
    .start_flag(start_flag), .loading(loading), .err_len(err_len),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_errors  = 0;
  int start_cnt = 0;

  logic [31:0] model_mem [DEPTH];
  bit          in_run = 1'b0;

  always @(negedge clk) if (start_flag === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int g);
    rx_valid = 1'b0;
    repeat (g) tick();
    check("rx_ready_load", 32'(rx_ready), 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap(max_gap));
  endtask

  task automatic fetch(input logic [15:0] a);
    logic [31:0] exp;
    lc = a;
    #2;
    exp = in_run ? model_mem[a[ADDR_W+1:2]] : NOP;
    check("fetch", instr_load, exp);
    tick();
  endtask

  task automatic fetch_idx(input int idx);
    logic [15:0] a;
    a = 16'($urandom);
    a[ADDR_W+1:2] = ADDR_W'(idx);
    fetch(a);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    in_run = 1'b0;
    check("reload_loading", 32'(loading), 32'd1);
    check("reload_words", 32'(words_loaded), 32'd0);
    check("reload_err", 32'(err_len), 32'd0);
  endtask

  task automatic load_program(input logic [31:0] words[$], input int max_gap);
    int          s0;
    logic [15:0] n;
    s0 = start_cnt;
    n  = 16'(words.size());
    send_byte(n[7:0], gap(max_gap));
    send_byte(n[15:8], gap(max_gap));
    lc = 16'($urandom);
    #1;
    check("load_nop", instr_load, NOP);
    check("load_loading", 32'(loading), 32'd1);
    foreach (words[i]) begin
      send_word(words[i], max_gap);
      check("words_loaded", 32'(words_loaded), 32'(i + 1));
    end
    check("start_pulse", 32'(start_flag), 32'd1);
    check("start_ready", 32'(rx_ready), 32'd0);
    tick();
    check("start_end", 32'(start_flag), 32'd0);
    check("run_loading", 32'(loading), 32'd0);
    check("start_count", 32'(start_cnt - s0), 32'd1);
    foreach (words[i]) model_mem[i] = words[i];
    in_run = 1'b1;
  endtask

  task automatic err_case(input logic [7:0] lo, input logic [7:0] hi);
    int s0;
    do_reload();
    s0 = start_cnt;
    send_byte(lo, 0);
    send_byte(hi, 0);
    check("err_len", 32'(err_len), 32'd1);
    check("err_ready", 32'(rx_ready), 32'd0);
    check("err_loading", 32'(loading), 32'd1);
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    repeat (3) tick();
    rx_valid = 1'b0;
    check("err_sticky", 32'(err_len), 32'd1);
    check("err_ready2", 32'(rx_ready), 32'd0);
    check("err_words", 32'(words_loaded), 32'd0);
    check("err_nostart", 32'(start_cnt - s0), 32'd0);
    fetch(16'($urandom));
    fetch(16'($urandom));
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] w;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; reload = 1'b0; lc = 16'd0;
    #3;
    check("rst_ready", 32'(rx_ready), 32'd1);
    check("rst_start", 32'(start_flag), 32'd0);
    check("rst_err", 32'(err_len), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_loading", 32'(loading), 32'd1);
    check("rst_nop", instr_load, NOP);
    tick();
    rst_n = 1'b1;
    tick();

    // Normal load with fixed program
    q = '{32'h0010_0513, 32'h0020_0593};
    load_program(q, 0);
    check("mem0_const", model_mem[0], 32'h0010_0513);
    fetch(16'h0000);
    fetch(16'h0004);
    fetch(16'h1004);

    // Reload from RUN, single word
    do_reload();
    q = '{32'hDEAD_BEEF};
    load_program(q, 0);
    fetch(16'h0000);
    fetch(16'h0004);

    // Gapped valid with the original program
    do_reload();
    q = '{32'h0010_0513, 32'h0020_0593};
    load_program(q, 3);
    check("gap_words", 32'(words_loaded), 32'd2);
    fetch_idx(0);
    fetch_idx(1);

    // Illegal lengths
    err_case(8'h00, 8'h00);
    err_case(8'h01, 8'h04);

    // Reload collides with the final byte of word 1
    do_reload();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    w = $urandom;
    send_word(w, 0);
    model_mem[0] = w;
    w = $urandom;
    for (int b = 0; b < 3; b++) send_byte(w[8*b +: 8], 0);
    rx_data = w[31:24]; rx_valid = 1'b1; reload = 1'b1;
    tick();
    rx_valid = 1'b0; reload = 1'b0;
    check("coll_words", 32'(words_loaded), 32'd0);
    check("coll_loading", 32'(loading), 32'd1);
    check("coll_ready", 32'(rx_ready), 32'd1);
    q = '{32'($urandom)};
    load_program(q, 0);
    fetch(16'h0000);
    fetch(16'h0004);

    // Random programs
    for (int k = 0; k < 3; k++) begin
      int n;
      n = int'($urandom_range(8, 1));
      q.delete();
      for (int i = 0; i < n; i++) q.push_back($urandom);
      do_reload();
      load_program(q, 3);
      for (int i = 0; i < n; i++) fetch_idx(i);
    end

    // Maximum legal length fills the whole memory
    q.delete();
    for (int i = 0; i < int'(DEPTH); i++) q.push_back($urandom);
    do_reload();
    load_program(q, 0);
    fetch_idx(0);
    fetch_idx(int'(DEPTH) - 1);
    for (int i = 0; i < 12; i++) fetch_idx(int'($urandom_range(DEPTH - 1, 0)));

    // Async reset after two bytes of word 1
    do_reload();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    w = $urandom;
    send_word(w, 0);
    model_mem[0] = w;
    w = $urandom;
    send_byte(w[7:0], 0);
    send_byte(w[15:8], 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(rx_ready), 32'd1);
    check("arst_words", 32'(words_loaded), 32'd0);
    check("arst_loading", 32'(loading), 32'd1);
    check("arst_start", 32'(start_flag), 32'd0);
    check("arst_nop", instr_load, NOP);
    check("arst_mem0", dut.mem[0], model_mem[0]);
    tick();
    tick();
    rst_n = 1'b1;
    in_run = 1'b0;
    tick();
    q = '{32'($urandom)};
    load_program(q, 2);
    fetch(16'h0000);
    fetch(16'h0004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
